fetcher: RTL

Instruction fetch stage. Holds the architectural fetch PC and requests 32-bit instructions from the instruction-memory/icache port. Hands one instruction per issue to the decoder together with its PC and a predicted-taken flag. Stalls while any back-end structure (ROB, RS, LSB) is full, and redirects on a ROB mispredict flush.

---
 rtl/fetcher_pkg.sv | 27 ++
 rtl/fetcher_branch_predictor.sv | 34 +++
 rtl/fetcher.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fetcher_pkg.sv
// fetcher_pkg: shared types, opcodes, FSM encodings and immediate/counter helpers for the fetch stage.
package fetcher_pkg;
    typedef logic [31:0] INS_TYPE;
    typedef logic [31:0] DATA_TYPE;
    localparam int OPCODE_RANGE = 7;
    localparam logic [OPCODE_RANGE-1:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [OPCODE_RANGE-1:0] OPCODE_BRANCH = 7'b1100011;
    localparam DATA_TYPE ZERO_WORD = 32'h0;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic [1:0] FETCH_IDLE = 2'd0;
    localparam logic [1:0] FETCH_WAIT = 2'd1;
    localparam logic [1:0] FETCH_HOLD = 2'd2;
    localparam logic [1:0] FETCH_DROP = 2'd3;

    function automatic DATA_TYPE imm_j(input INS_TYPE i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic DATA_TYPE imm_b(input INS_TYPE i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic t);
        return t ? (c == 2'b11 ? c : c + 2'b01) : (c == 2'b00 ? c : c - 2'b01);
    endfunction
endpackage

// File: rtl/fetcher_branch_predictor.sv
// branch_predictor: table of 2-bit saturating counters indexed by pc[IDX_W+1:2];
// reads are combinational so a same-cycle update is seen only from the next cycle.
module branch_predictor
    import fetcher_pkg::*;
#(
    parameter int ENTRIES = 256,
    parameter int IDX_W   = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy_i,
    input  DATA_TYPE pc_i,
    output logic     predict_taken_o,
    input  logic     commit_i,
    input  DATA_TYPE commit_pc_i,
    input  logic     commit_taken_i
);
    logic [1:0] bht_q [ENTRIES];
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic unused_pc;

    assign rd_idx = pc_i[IDX_W+1:2];
    assign wr_idx = commit_pc_i[IDX_W+1:2];
    assign unused_pc = ^{pc_i[31:IDX_W+2], pc_i[1:0], commit_pc_i[31:IDX_W+2], commit_pc_i[1:0]};
    assign predict_taken_o = bht_q[rd_idx][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) bht_q[i] <= 2'b01;
        end else if (rdy_i && commit_i) begin
            bht_q[wr_idx] <= ctr_next(bht_q[wr_idx], commit_taken_i);
        end
    end
endmodule

// File: rtl/fetcher.sv
// fetcher: instruction fetch FSM with hold buffer, flush redirect and next-PC prediction.
// Build option FETCHER_BHT_EN enables the branch history table; otherwise branches predict not-taken.
module fetcher
    import fetcher_pkg::*;
#(
    parameter int BHT_ENTRIES = 256,
    parameter int BHT_IDX_W   = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    output logic     out_mem_req,
    output DATA_TYPE out_mem_pc,
    input  logic     in_mem_valid,
    input  INS_TYPE  in_mem_inst,
    output logic     out_dcd_valid,
    output INS_TYPE  out_dcd_inst,
    output DATA_TYPE out_dcd_pc,
    output logic     out_dcd_jump_flag,
    input  logic     in_rob_full,
    input  logic     in_rs_full,
    input  logic     in_lsb_full,
    input  logic     in_rob_mispredict,
    input  DATA_TYPE in_rob_newpc,
    input  logic     in_rob_br_commit,
    input  DATA_TYPE in_rob_br_pc,
    input  logic     in_rob_br_taken
);
    logic [1:0] state_q, state_d;
    DATA_TYPE pc_q, pc_d, mem_pc_q, mem_pc_d, dcd_pc_q, dcd_pc_d, next_pc;
    INS_TYPE hold_q, hold_d, dcd_inst_q, dcd_inst_d, inst;
    logic mem_req_q, mem_req_d, dcd_valid_q, dcd_valid_d, dcd_jump_q, dcd_jump_d;
    logic stall, issue, is_jal, is_br, pred_taken, take;

`ifdef FETCHER_BHT_EN
    branch_predictor #(.ENTRIES(BHT_ENTRIES), .IDX_W(BHT_IDX_W)) u_bp (
        .clk            (clk),
        .rst            (rst),
        .rdy_i          (rdy),
        .pc_i           (pc_q),
        .predict_taken_o(pred_taken),
        .commit_i       (in_rob_br_commit),
        .commit_pc_i    (in_rob_br_pc),
        .commit_taken_i (in_rob_br_taken)
    );
`else
    logic unused_br;
    assign unused_br = ^{in_rob_br_commit, in_rob_br_pc, in_rob_br_taken, BHT_ENTRIES[0], BHT_IDX_W[0]};
    assign pred_taken = FALSE;
`endif

    assign stall = in_rob_full | in_rs_full | in_lsb_full;
    assign inst = state_q == FETCH_HOLD ? hold_q : in_mem_inst;
    assign issue = !in_rob_mispredict && !stall &&
                   (state_q == FETCH_HOLD || (state_q == FETCH_WAIT && in_mem_valid));
    assign is_jal = inst[OPCODE_RANGE-1:0] == OPCODE_JAL;
    assign is_br = inst[OPCODE_RANGE-1:0] == OPCODE_BRANCH;
    assign take = is_jal | (is_br & pred_taken);
    assign next_pc = pc_q + (is_jal ? imm_j(inst) : take ? imm_b(inst) : 32'd4);

    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        hold_d = hold_q;
        mem_req_d = mem_req_q;
        mem_pc_d = mem_pc_q;
        dcd_valid_d = issue;
        dcd_inst_d = issue ? inst : ZERO_WORD;
        dcd_pc_d = issue ? pc_q : dcd_pc_q;
        dcd_jump_d = issue ? take : FALSE;
        if (in_rob_mispredict) begin
            // an outstanding request must still be drained unless its word arrives now
            pc_d = in_rob_newpc;
            hold_d = ZERO_WORD;
            mem_req_d = (state_q == FETCH_WAIT || state_q == FETCH_DROP) && !in_mem_valid;
            state_d = mem_req_d ? FETCH_DROP : FETCH_IDLE;
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    mem_req_d = TRUE;
                    mem_pc_d = pc_q;
                    state_d = FETCH_WAIT;
                end
                FETCH_WAIT: if (in_mem_valid) begin
                    mem_req_d = FALSE;
                    hold_d = stall ? in_mem_inst : hold_q;
                    state_d = stall ? FETCH_HOLD : FETCH_IDLE;
                end
                FETCH_HOLD: state_d = stall ? FETCH_HOLD : FETCH_IDLE;
                default: if (in_mem_valid) begin
                    mem_req_d = FALSE;
                    state_d = FETCH_IDLE;
                end
            endcase
            pc_d = issue ? next_pc : pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_IDLE;
            pc_q <= ZERO_WORD;
            hold_q <= ZERO_WORD;
            mem_req_q <= FALSE;
            mem_pc_q <= ZERO_WORD;
            dcd_valid_q <= FALSE;
            dcd_inst_q <= ZERO_WORD;
            dcd_pc_q <= ZERO_WORD;
            dcd_jump_q <= FALSE;
        end else if (rdy) begin
            state_q <= state_d;
            pc_q <= pc_d;
            hold_q <= hold_d;
            mem_req_q <= mem_req_d;
            mem_pc_q <= mem_pc_d;
            dcd_valid_q <= dcd_valid_d;
            dcd_inst_q <= dcd_inst_d;
            dcd_pc_q <= dcd_pc_d;
            dcd_jump_q <= dcd_jump_d;
        end
    end

    assign out_mem_req = mem_req_q;
    assign out_mem_pc = mem_pc_q;
    assign out_dcd_valid = dcd_valid_q;
    assign out_dcd_inst = dcd_inst_q;
    assign out_dcd_pc = dcd_pc_q;
    assign out_dcd_jump_flag = dcd_jump_q;
endmodule
